bin_onehot_codec: RTL and testbench
===================================

# bin_onehot_codec

Parametrised, registered binary/one-hot codec with a valid/ready stream interface. It replaces the purely combinational binary-to-one-hot decoder wherever results must cross a pipeline stage or tolerate backpressure. The block supports three modes: decode, encode with legality checking, and one-hot rotate. Results pass through a 2-entry skid buffer, and a saturating counter tracks illegal transactions.

## Interface
- BIN_W, 4, binary width.
- ONE_HOT_W, 16, one-hot width; legal range 2 ≤ ONE_HOT_W ≤ 2**BIN_W.
- ERR_CNT_W, 16, error counter width.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- valid_i  in  1  input transaction valid.
- ready_o  out  1  block can accept an input this cycle.
- mode_i  in  2  transaction mode: 00 DEC, 01 ENC, 10 ROT, 11 reserved.
- bin_i  in  BIN_W  binary index (DEC) or rotate amount (ROT).
- one_hot_i  in  ONE_HOT_W  one-hot vector (ENC, ROT).
- valid_o  out  1  output transaction valid.
- ready_i  in  1  downstream accepts the output.
- bin_o  out  BIN_W  binary result.
- one_hot_o  out  ONE_HOT_W  one-hot result.
- err_o  out  1  the transaction at the output was illegal.
- err_cnt_o  out  ERR_CNT_W  saturating count of accepted illegal transactions.

## Operation
- Push: valid_i && ready_o. Pop: valid_o && ready_i.
- DEC mode:
  - bin_i < ONE_HOT_W: one_hot_o = 1 << bin_i, bin_o = bin_i, err = 0.
  - Otherwise: one_hot_o = 0, bin_o = bin_i, err = 1.
- ENC mode:
  - bin_o = index of the lowest set bit of one_hot_i (0 if none).
  - one_hot_o = the isolated lowest set bit.
  - err = 1 if one_hot_i is zero or has more than one bit set.
- ROT mode:
  - one_hot_o = one_hot_i rotated left by (bin_i mod ONE_HOT_W).
  - bin_o = (encoded index + bin_i) mod ONE_HOT_W.
  - err and zero/multi-hot handling follow ENC rules; on error, the rotation still applies to the raw vector.
- Mode 11: all outputs zero, err = 1.
- Result computation is combinational on the inputs. The {bin, one_hot, err} tuple is written into the skid buffer on push.
- Skid buffer FSM (state enum):
  - EMPTY -push-> ONE.
  - ONE -push&&!pop-> FULL.
  - ONE -pop&&!push-> EMPTY.
  - ONE -push&&pop-> ONE, with the new entry at the head.
  - FULL -pop-> ONE.
  - ready_o = (state != FULL); valid_o = (state != EMPTY).
- err_cnt_o increments on every push whose err = 1 and saturates at all-ones (no wrap).
- Outputs are held stable while valid_o && !ready_i.

## Timing
- Latency is 1 cycle: a push at edge N makes the result visible on valid_o after edge N, provided the buffer was empty.
- Throughput is 1 transaction/cycle with ready_i held high.
- ready_o is a registered-state function and does not depend combinationally on ready_i.
- Reset values (asynchronous):
  - valid_o = 0, bin_o = 0, one_hot_o = 0, err_o = 0, err_cnt_o = 0.
  - State = EMPTY, so ready_o = 1 once reset_n is high.
- Reset mid-operation discards all buffered entries and clears the counter immediately.
- In FULL, no push is possible. A pop in FULL frees one slot, and ready_o rises the following cycle.
- err_cnt_o updates on the cycle after the push edge, in parallel with the data.

## Structure
- Package bin_onehot_pkg:
  - mode_e enum: DEC, ENC, ROT, RSVD.
  - skid_state_e enum: EMPTY, ONE, FULL.
  - Result struct {bin, one_hot, err}.
- Sub-module onehot_skid_buf: 2-entry valid/ready buffer, parametrised on payload width, containing the FSM.
- The top level holds the mode datapath and the error counter.

## Test plan
- DEC sweep: BIN_W = 4, ONE_HOT_W = 12, bin_i = 0..15, ready_i = 1.
  - bin_i 5 -> one_hot_o 0x020, err_o 0.
  - bin_i 13 -> one_hot_o 0, err_o 1; err_cnt_o ends at 4.
- ENC: one_hot_i 0x0400 -> bin_o 10, err 0; 0x0000 -> bin_o 0, err 1; 0x0014 -> bin_o 2, one_hot_o 0x0004, err 1.
- ROT (ONE_HOT_W = 16): one_hot_i 0x8000, bin_i 3 -> one_hot_o 0x0004, bin_o 2.
- Backpressure: ready_i = 0 with 3 back-to-back pushes.
  - ready_o drops after the 2nd push.
  - Outputs stay stable.
  - Releasing ready_i drains the results in order.
- Simultaneous push and pop in ONE: the state stays ONE and the new result appears the next cycle.
- Saturation and reset: ERR_CNT_W = 2 with 5 illegal pushes holds err_cnt_o at 3. Asserting reset_n low with 2 buffered entries immediately gives valid_o 0 and err_cnt_o 0, then ready_o 1 after release.

Source files
------------

// File: rtl/bin_onehot_pkg.sv
// Shared types for the binary/one-hot codec: transaction modes, skid-buffer
// states and the result payload layout.
package bin_onehot_pkg;

  localparam int unsigned DEF_BIN_W     = 4;
  localparam int unsigned DEF_ONE_HOT_W = 16;

  typedef enum logic [1:0] {
    DEC  = 2'b00,
    ENC  = 2'b01,
    ROT  = 2'b10,
    RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

  // Result payload for the default codec geometry; the top mirrors this layout
  // with its own parameter widths.
  typedef struct packed {
    logic [DEF_BIN_W-1:0]     bin;
    logic [DEF_ONE_HOT_W-1:0] one_hot;
    logic                     err;
  } result_t;

endpackage

// File: rtl/onehot_skid_buf.sv
// Two-entry valid/ready skid buffer. The head register drives the output
// directly, so data and valid are registered and ready depends only on state.
module onehot_skid_buf
  import bin_onehot_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              push, pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Next state and entry loads; a push that coincides with a pop in ONE replaces the head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    push    = valid_i && (state_q != FULL);
    pop     = ready_i && (state_q != EMPTY);
    case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = data_i;
        end else if (push) begin
          tail_d  = data_i;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign ready_o = (state_q != FULL);
  assign valid_o = (state_q != EMPTY);
  assign data_o  = head_q;

endmodule

// File: rtl/bin_onehot_codec.sv
// Registered binary/one-hot codec (decode, checked encode, one-hot rotate)
// behind a 2-entry skid buffer, with a saturating illegal-transaction counter.
module bin_onehot_codec
  import bin_onehot_pkg::*;
#(
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned ONE_HOT_W = 16,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           mode_i,
  input  logic [BIN_W-1:0]     bin_i,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BIN_W-1:0]     bin_o,
  output logic [ONE_HOT_W-1:0] one_hot_o,
  output logic                 err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  typedef struct packed {
    logic [BIN_W-1:0]     bin;
    logic [ONE_HOT_W-1:0] one_hot;
    logic                 err;
  } codec_res_t;

  localparam int unsigned RES_W = $bits(codec_res_t);

  mode_e                  mode;
  logic [ONE_HOT_W-1:0]   low_bit;
  logic [BIN_W-1:0]       low_idx;
  logic                   hot_err;
  logic [BIN_W-1:0]       rot_amt;
  logic [BIN_W-1:0]       rot_bin;
  logic [2*ONE_HOT_W-1:0] rot_dbl;
  codec_res_t             res;
  codec_res_t             out_q;
  logic                   push;
  logic [ERR_CNT_W-1:0]   err_cnt_q;

  assign mode = mode_e'(mode_i);

  // Lowest-set-bit isolation, its index, and zero/multi-hot detection.
  always_comb begin
    low_bit = one_hot_i & (~one_hot_i + ONE_HOT_W'(1));
    low_idx = '0;
    for (int i = int'(ONE_HOT_W) - 1; i >= 0; i--) begin
      if (one_hot_i[i]) low_idx = BIN_W'(i);
    end
    hot_err = (one_hot_i == '0) || ((one_hot_i & (one_hot_i - ONE_HOT_W'(1))) != '0);
  end

  // Rotate via a doubled vector so non-power-of-two widths wrap correctly.
  always_comb begin
    rot_amt = BIN_W'(32'(bin_i) % ONE_HOT_W);
    rot_dbl = {one_hot_i, one_hot_i} << rot_amt;
    rot_bin = BIN_W'((32'(low_idx) + 32'(bin_i)) % ONE_HOT_W);
  end

  always_comb begin
    res = '0;
    case (mode)
      DEC: begin
        res.bin = bin_i;
        if (32'(bin_i) < ONE_HOT_W) res.one_hot = ONE_HOT_W'(1) << bin_i;
        else                        res.err     = 1'b1;
      end
      ENC: begin
        res.bin     = low_idx;
        res.one_hot = low_bit;
        res.err     = hot_err;
      end
      ROT: begin
        res.bin     = rot_bin;
        res.one_hot = rot_dbl[2*ONE_HOT_W-1 -: ONE_HOT_W];
        res.err     = hot_err;
      end
      default: res.err = 1'b1;
    endcase
  end

  assign push = valid_i && ready_o;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (push && res.err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  onehot_skid_buf #(
    .DATA_W (RES_W)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (res),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (out_q)
  );

  assign bin_o     = out_q.bin;
  assign one_hot_o = out_q.one_hot;
  assign err_o     = out_q.err;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_bin_onehot_codec.sv
// Scoreboard bench for bin_onehot_codec: accepted transactions are scored by a
// behavioural model and compared in order as the DUT presents results.
module tb_bin_onehot_codec;

  localparam int unsigned BW = 4;
  localparam int unsigned OW = 12;
  localparam int unsigned CW = 3;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [1:0]    mode_i  = '0;
  logic [BW-1:0] bin_i   = '0;
  logic [OW-1:0] one_hot_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [BW-1:0] bin_o;
  logic [OW-1:0] one_hot_o;
  logic          err_o;
  logic [CW-1:0] err_cnt_o;

  always #5 clk = ~clk;

  bin_onehot_codec #(
    .BIN_W     (BW),
    .ONE_HOT_W (OW),
    .ERR_CNT_W (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .mode_i    (mode_i),
    .bin_i     (bin_i),
    .one_hot_i (one_hot_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .bin_o     (bin_o),
    .one_hot_o (one_hot_o),
    .err_o     (err_o),
    .err_cnt_o (err_cnt_o)
  );

  typedef struct {
    logic [BW-1:0] bin;
    logic [OW-1:0] oh;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   model_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model built from the mode rules with bit counting and index arithmetic.
  function automatic exp_t model(input logic [1:0] m, input logic [BW-1:0] b, input logic [OW-1:0] oh);
    exp_t e;
    int   ones;
    int   low;
    int   amt;
    e.bin = '0;
    e.oh  = '0;
    e.err = 1'b0;
    ones  = $countones(oh);
    low   = 0;
    for (int i = int'(OW) - 1; i >= 0; i--) if (oh[i]) low = i;
    case (m)
      2'd0: begin
        e.bin = b;
        if (int'(b) < int'(OW)) e.oh = OW'(1) << b;
        else                    e.err = 1'b1;
      end
      2'd1: begin
        e.bin = BW'(low);
        e.oh  = (ones == 0) ? '0 : (OW'(1) << low);
        e.err = (ones != 1);
      end
      2'd2: begin
        amt = int'(b) % int'(OW);
        for (int i = 0; i < int'(OW); i++) e.oh[(i + amt) % int'(OW)] = oh[i];
        e.bin = BW'((low + int'(b)) % int'(OW));
        e.err = (ones != 1);
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  // Monitor/scoreboard: compare the head first, then record this cycle's push.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      check("valid_o", 32'(valid_o), 32'(sb_q.size() != 0));
      check("ready_o", 32'(ready_o), 32'(sb_q.size() < 2));
      check("err_cnt_o", 32'(err_cnt_o), 32'(model_cnt));
      if (valid_o && sb_q.size() != 0) begin
        check("bin_o", 32'(bin_o), 32'(sb_q[0].bin));
        check("one_hot_o", 32'(one_hot_o), 32'(sb_q[0].oh));
        check("err_o", 32'(err_o), 32'(sb_q[0].err));
        if (ready_i) void'(sb_q.pop_front());
      end
      if (valid_i && ready_o) begin
        e = model(mode_i, bin_i, one_hot_i);
        sb_q.push_back(e);
        if (e.err && model_cnt < (2 ** CW) - 1) model_cnt++;
      end
    end
  end

  task automatic send(input logic v, input logic [1:0] m, input logic [BW-1:0] b, input logic [OW-1:0] oh);
    @(posedge clk);
    #1;
    valid_i   = v;
    mode_i    = m;
    bin_i     = b;
    one_hot_i = oh;
  endtask

  task automatic drain();
    logic done;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    done    = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!valid_o) done = 1'b1;
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  // One transaction into an empty buffer, checked against fixed expected values.
  task automatic single(input string name, input logic [1:0] m, input logic [BW-1:0] b,
                        input logic [OW-1:0] oh, input logic [BW-1:0] eb,
                        input logic [OW-1:0] eoh, input logic ee);
    send(1'b1, m, b, oh);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check({name, "_valid"}, 32'(valid_o), 32'd1);
    check({name, "_bin"}, 32'(bin_o), 32'(eb));
    check({name, "_onehot"}, 32'(one_hot_o), 32'(eoh));
    check({name, "_err"}, 32'(err_o), 32'(ee));
  endtask

  initial begin
    logic acc;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_bin", 32'(bin_o), 32'd0);
    check("rst_onehot", 32'(one_hot_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_cnt", 32'(err_cnt_o), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd1);

    // Back-to-back decode sweep across the legal/illegal boundary.
    for (int b = 0; b < 16; b++) send(1'b1, 2'd0, BW'(b), '0);
    drain();
    check("dec_sweep_cnt", 32'(err_cnt_o), 32'd4);

    single("dec5", 2'd0, 4'd5, '0, 4'd5, 12'h020, 1'b0);
    single("dec13", 2'd0, 4'd13, '0, 4'd13, 12'h000, 1'b1);
    single("enc400", 2'd1, 4'd0, 12'h400, 4'd10, 12'h400, 1'b0);
    single("enc000", 2'd1, 4'd0, 12'h000, 4'd0, 12'h000, 1'b1);
    single("enc014", 2'd1, 4'd0, 12'h014, 4'd2, 12'h004, 1'b1);
    single("rot800", 2'd2, 4'd3, 12'h800, 4'd2, 12'h004, 1'b0);
    single("rsvd", 2'd3, 4'd7, 12'hfff, 4'd0, 12'h000, 1'b1);
    drain();
    check("sat_cnt", 32'(err_cnt_o), 32'd7);

    // Backpressure: three pushes against a stalled output.
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    send(1'b1, 2'd0, 4'd1, '0);
    send(1'b1, 2'd0, 4'd2, '0);
    send(1'b1, 2'd0, 4'd3, '0);
    @(negedge clk);
    check("bp_ready_low", 32'(ready_o), 32'd0);
    check("bp_head", 32'(one_hot_o), 32'h002);
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", 32'(one_hot_o), 32'h002);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      @(negedge clk);
      if (ready_o) acc = 1'b1;
    end
    check("bp_accept", 32'(acc), 32'd1);
    drain();

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      valid_i = ($urandom_range(0, 3) != 0);
      mode_i  = 2'($urandom_range(0, 3));
      bin_i   = BW'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       one_hot_i = '0;
        1:       one_hot_i = OW'(1) << $urandom_range(0, OW - 1);
        default: one_hot_i = OW'($urandom);
      endcase
      ready_i = ($urandom_range(0, 3) != 0);
    end
    drain();

    // Reset with two entries buffered and the counter saturated.
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    send(1'b1, 2'd1, 4'd0, 12'h000);
    send(1'b1, 2'd1, 4'd0, 12'h003);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    @(negedge clk);
    check("pre_rst_full", 32'(ready_o), 32'd0);
    check("pre_rst_cnt", 32'(err_cnt_o), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
    check("mid_rst_onehot", 32'(one_hot_o), 32'd0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    ready_i = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(ready_o), 32'd1);
    check("post_rst_valid", 32'(valid_o), 32'd0);
    single("post_rst_dec", 2'd0, 4'd11, '0, 4'd11, 12'h800, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
